cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 39 +++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-source/CDB bundle between functional units and cdb_arbiter.
// The squash line exists only when CDB_SQUASH_EN is defined.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int XLEN   = 32
);
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       fu_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_reg_tag;
  logic [XLEN-1:0]         cdb_reg_value;

`ifdef CDB_SQUASH_EN
  logic                    squash;

  modport master (
    output fu_valid, fu_tag, fu_value, squash,
    input  fu_ready, cdb_valid, cdb_reg_tag, cdb_reg_value
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value, squash,
    output fu_ready, cdb_valid, cdb_reg_tag, cdb_reg_value
  );
`else
  modport master (
    output fu_valid, fu_tag, fu_value,
    input  fu_ready, cdb_valid, cdb_reg_tag, cdb_reg_value
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value,
    output fu_ready, cdb_valid, cdb_reg_tag, cdb_reg_value
  );
`endif
endinterface

// File: rtl/cdb_arbiter.sv
// Per-FU 2-deep result FIFOs arbitrated round-robin onto a registered CDB; accept at edge N -> broadcast after N+1.
// fu_ready is FIFO-not-full from state only; squash/flush logic is built only with CDB_SQUASH_EN.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int XLEN   = 32
) (
  input  logic         clock,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [TAG_W-1:0]  tag_mem [NUM_FU][2];
  logic [XLEN-1:0]   val_mem [NUM_FU][2];
  logic [1:0]        cnt     [NUM_FU];
  logic [NUM_FU-1:0] rd_ptr;
  logic [NUM_FU-1:0] wr_ptr;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [XLEN-1:0]   cdb_value_q;

  // Tag-0 results complete the handshake but never occupy a FIFO slot.
  always_comb begin
    full = '0;
    push = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      full[i] = (cnt[i] == 2'd2);
      push[i] = bus.fu_valid[i] && !full[i] && (bus.fu_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  assign bus.fu_ready = ~full;

  // Scan downward so the last hit is the first non-empty FIFO at or after rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (cnt[(int'(rr_ptr) + k) % NUM_FU] != 2'd0) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'((int'(rr_ptr) + k) % NUM_FU);
      end
    end
    pop = '0;
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      rr_ptr      <= '0;
      for (int i = 0; i < NUM_FU; i++) cnt[i] <= 2'd0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end
`ifdef CDB_SQUASH_EN
    else if (bus.squash) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < NUM_FU; i++) cnt[i] <= 2'd0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end
`endif
    else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) begin
          tag_mem[i][wr_ptr[i]] <= bus.fu_tag[i*TAG_W +: TAG_W];
          val_mem[i][wr_ptr[i]] <= bus.fu_value[i*XLEN +: XLEN];
          wr_ptr[i]             <= ~wr_ptr[i];
        end
        if (pop[i]) rd_ptr[i] <= ~rd_ptr[i];
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end

      if (gnt_vld) begin
        cdb_valid_q <= 1'b1;
        cdb_tag_q   <= tag_mem[gnt_idx][rd_ptr[gnt_idx]];
        cdb_value_q <= val_mem[gnt_idx][rd_ptr[gnt_idx]];
        rr_ptr      <= (int'(gnt_idx) == NUM_FU - 1) ? '0 : gnt_idx + 1'b1;
      end else begin
        cdb_valid_q <= 1'b0;
        cdb_tag_q   <= '0;
        cdb_value_q <= '0;
      end
    end
  end

  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_reg_tag   = cdb_tag_q;
  assign bus.cdb_reg_value = cdb_value_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int NF = 4;
  localparam int TW = 5;
  localparam int XW = 32;

  typedef struct packed {
    int            fu;
    logic [TW-1:0] tag;
    logic [XW-1:0] val;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit   sq_drv = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state: all pending results in arrival order, tagged by source.
  ent_t          pend[$];
  int            rr = 0;
  logic          exp_vld = 1'b0;
  logic [TW-1:0] exp_tag = '0;
  logic [XW-1:0] exp_val = '0;

  cdb_arbiter_if #(.NUM_FU(NF), .TAG_W(TW), .XLEN(XW)) bus ();

  cdb_arbiter #(.NUM_FU(NF), .TAG_W(TW), .XLEN(XW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int occ(int f);
    int n = 0;
    foreach (pend[j]) if (pend[j].fu == f) n++;
    return n;
  endfunction

  task automatic model_edge();
    bit   rdy [NF];
    int   g;
    int   idx;
    ent_t e;
    if (reset) begin
      pend.delete();
      rr = 0;
      exp_vld = 0; exp_tag = '0; exp_val = '0;
      return;
    end
    if (sq_drv) begin
      pend.delete();
      exp_vld = 0; exp_tag = '0; exp_val = '0;
      return;
    end
    for (int i = 0; i < NF; i++) rdy[i] = occ(i) < 2;
    g = -1;
    for (int k = 0; k < NF; k++) begin
      idx = (rr + k) % NF;
      if (g < 0 && occ(idx) > 0) g = idx;
    end
    if (g >= 0) begin
      for (int j = 0; j < pend.size(); j++) begin
        if (pend[j].fu == g) begin
          e = pend[j];
          pend.delete(j);
          break;
        end
      end
      exp_vld = 1; exp_tag = e.tag; exp_val = e.val;
      rr = (g + 1) % NF;
    end else begin
      exp_vld = 0; exp_tag = '0; exp_val = '0;
    end
    for (int i = 0; i < NF; i++) begin
      if (bus.fu_valid[i] && rdy[i] && bus.fu_tag[i*TW +: TW] != '0) begin
        e.fu = i;
        e.tag = bus.fu_tag[i*TW +: TW];
        e.val = bus.fu_value[i*XW +: XW];
        pend.push_back(e);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check("cdb_valid", {63'd0, bus.cdb_valid}, {63'd0, exp_vld});
    check("cdb_reg_tag", {59'd0, bus.cdb_reg_tag}, {59'd0, exp_tag});
    check("cdb_reg_value", {32'd0, bus.cdb_reg_value}, {32'd0, exp_val});
    for (int i = 0; i < NF; i++)
      check("fu_ready", {63'd0, bus.fu_ready[i]}, {63'd0, occ(i) < 2});
  endtask

  task automatic drive(int f, bit v, logic [TW-1:0] t, logic [XW-1:0] d);
    bus.fu_valid[f]          = v;
    bus.fu_tag[f*TW +: TW]   = t;
    bus.fu_value[f*XW +: XW] = d;
  endtask

  task automatic idle();
    for (int i = 0; i < NF; i++) drive(i, 1'b0, '0, '0);
  endtask

  task automatic set_sq(bit v);
    sq_drv = v;
`ifdef CDB_SQUASH_EN
    bus.squash = v;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    bit saw_low;
    idle();
    set_sq(1'b0);

    // Reset state
    do_reset();
    check("rst_valid", {63'd0, bus.cdb_valid}, 64'd0);
    check("rst_ready", {60'd0, bus.fu_ready}, 64'hf);

    // Single result minimum latency
    drive(1, 1'b1, 5'd3, 32'h10);
    step();
    check("lat_n_valid", {63'd0, bus.cdb_valid}, 64'd0);
    idle();
    step();
    check("lat_n1_valid", {63'd0, bus.cdb_valid}, 64'd1);
    check("lat_n1_tag", {59'd0, bus.cdb_reg_tag}, 64'd3);
    check("lat_n1_value", {32'd0, bus.cdb_reg_value}, 64'h10);
    step();
    check("lat_n2_valid", {63'd0, bus.cdb_valid}, 64'd0);
    check("lat_n2_value", {32'd0, bus.cdb_reg_value}, 64'd0);

    // All four FUs at once broadcast in round-robin order
    do_reset();
    for (int i = 0; i < NF; i++) drive(i, 1'b1, 5'(i + 1), 32'h100 + i);
    step();
    idle();
    for (int k = 0; k < NF; k++) begin
      step();
      check("rr_order_tag", {59'd0, bus.cdb_reg_tag}, 64'(k + 1));
    end

    // FU2 backpressured under contention
    do_reset();
    saw_low = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1'b1, 5'd1, 32'h000 + c);
      drive(1, 1'b1, 5'd2, 32'h100 + c);
      drive(2, 1'b1, 5'd3, 32'h200 + c);
      step();
      if (bus.fu_ready[2] == 1'b0) saw_low = 1'b1;
    end
    idle();
    for (int c = 0; c < 8; c++) step();
    check("fu2_backpressure", {63'd0, saw_low}, 64'd1);
    check("drained", 64'(pend.size()), 64'd0);

    // Tag 0 is never broadcast
    drive(0, 1'b1, 5'd0, 32'h55);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      step();
      check("tag0_valid", {63'd0, bus.cdb_valid}, 64'd0);
      check("tag0_tag", {59'd0, bus.cdb_reg_tag}, 64'd0);
    end

`ifdef CDB_SQUASH_EN
    // Squash with buffered results
    do_reset();
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 5'(i + 1), 32'h300 + i);
    step();
    idle();
    set_sq(1'b1);
    step();
    check("squash_valid", {63'd0, bus.cdb_valid}, 64'd0);
    check("squash_ready", {60'd0, bus.fu_ready}, 64'hf);
    set_sq(1'b0);
    step();
    check("post_squash_valid", {63'd0, bus.cdb_valid}, 64'd0);
`endif

    // Reset while results are buffered
    for (int i = 0; i < NF; i++) drive(i, 1'b1, 5'(i + 5), 32'h400 + i);
    step();
    step();
    idle();
    do_reset();
    check("midrst_valid", {63'd0, bus.cdb_valid}, 64'd0);
    check("midrst_tag", {59'd0, bus.cdb_reg_tag}, 64'd0);
    check("midrst_value", {32'd0, bus.cdb_reg_value}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("no_stale", {63'd0, bus.cdb_valid}, 64'd0);
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NF; i++) begin
        drive(i, $urandom_range(0, 99) < 60,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
`ifdef CDB_SQUASH_EN
      set_sq($urandom_range(0, 49) == 0);
`endif
      step();
    end
    reset = 1'b0;
    set_sq(1'b0);
    idle();
    for (int c = 0; c < 10; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
